// File: rtl/crossbar_pkg.sv
// Shared types and defaults for the crossbar output allocator.
package crossbar_pkg;

    localparam int unsigned PORTS_DEFAULT   = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 16;

    typedef enum logic {
        ALLOC_IDLE   = 1'b0,
        ALLOC_LOCKED = 1'b1
    } alloc_state_t;

endpackage

// File: rtl/crossbar_allocator_if.sv
// Request/grant bundle between the crossbar inputs, outputs and the allocator.
interface crossbar_allocator_if #(
    parameter int unsigned PORTS = crossbar_pkg::PORTS_DEFAULT
);
    localparam int unsigned DEST_W = $clog2(PORTS);

    logic [PORTS-1:0]             req_valid;
    logic [PORTS-1:0][DEST_W-1:0] req_dest;
    logic [PORTS-1:0]             req_last;
    logic [PORTS-1:0]             out_ready;
    logic [PORTS-1:0]             in_ready;
    logic [PORTS-1:0]             out_valid;
    logic [PORTS-1:0][DEST_W-1:0] xbar_dest;
    logic [PORTS-1:0]             xbar_dest_en;
    logic [PORTS-1:0]             lock_o;
    logic [PORTS-1:0]             timeout_o;

    modport master (
        output req_valid, req_dest, req_last, out_ready,
        input  in_ready, out_valid, xbar_dest, xbar_dest_en, lock_o, timeout_o
    );

    modport slave (
        input  req_valid, req_dest, req_last, out_ready,
        output in_ready, out_valid, xbar_dest, xbar_dest_en, lock_o, timeout_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request scanning cyclically upward from ptr.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_c,
    output logic [IDX_W-1:0] idx_c
);

    always_comb begin : pick
        int unsigned      c;
        logic [IDX_W-1:0] ci;
        logic             found;
        gnt_c = '0;
        idx_c = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            c  = (32'(ptr) + k) % N;
            ci = IDX_W'(c);
            if (!found && req[ci]) begin
                found     = 1'b1;
                gnt_c[ci] = 1'b1;
                idx_c     = ci;
            end
        end
    end

endmodule

// File: rtl/crossbar_allocator.sv
// Per-output packet-lock allocator for a PORTS x PORTS crossbar.
// Define CROSSBAR_ALLOC_TIMEOUT_EN to force-release locks stalled for TIMEOUT cycles.
module crossbar_allocator
    import crossbar_pkg::*;
#(
    parameter int unsigned PORTS   = PORTS_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    crossbar_allocator_if.slave bus
);

    localparam int unsigned DEST_W = $clog2(PORTS);

    alloc_state_t      state_q [PORTS];
    alloc_state_t      state_d [PORTS];
    logic [DEST_W-1:0] owner_q [PORTS];
    logic [DEST_W-1:0] owner_d [PORTS];
    logic [DEST_W-1:0] rr_q    [PORTS];
    logic [DEST_W-1:0] rr_d    [PORTS];

    logic [PORTS-1:0]  busy;
    logic [PORTS-1:0]  xfer;
    logic [PORTS-1:0]  expire;
    logic [PORTS-1:0]  elig    [PORTS];
    logic [PORTS-1:0]  gnt     [PORTS];
    logic [DEST_W-1:0] gidx    [PORTS];

    // An input already holding an output may not compete for another one.
    always_comb begin : busy_elig
        busy = '0;
        xfer = '0;
        for (int unsigned j = 0; j < PORTS; j++) begin
            if (state_q[j] == ALLOC_LOCKED) begin
                busy[owner_q[j]] = 1'b1;
                xfer[j]          = bus.req_valid[owner_q[j]] && bus.out_ready[j];
            end
        end
        for (int unsigned j = 0; j < PORTS; j++) begin
            elig[j] = '0;
            for (int unsigned i = 0; i < PORTS; i++) begin
                elig[j][i] = bus.req_valid[i] && (bus.req_dest[i] == DEST_W'(j)) && !busy[i];
            end
        end
    end

    for (genvar j = 0; j < PORTS; j++) begin : g_arb
        rr_arbiter #(.N(PORTS), .IDX_W(DEST_W)) u_arb (
            .req   (elig[j]),
            .ptr   (rr_q[j]),
            .gnt_c (gnt[j]),
            .idx_c (gidx[j])
        );
    end

`ifdef CROSSBAR_ALLOC_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q [PORTS];
    logic [CNT_W-1:0] cnt_d [PORTS];

    always_comb begin : expire_calc
        for (int unsigned j = 0; j < PORTS; j++) begin
            expire[j] = (state_q[j] == ALLOC_LOCKED) && (cnt_q[j] == CNT_W'(TIMEOUT));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : cnt_reg
        if (!rst_n) begin
            for (int unsigned j = 0; j < PORTS; j++) cnt_q[j] <= '0;
        end else begin
            for (int unsigned j = 0; j < PORTS; j++) cnt_q[j] <= cnt_d[j];
        end
    end
`else
    assign expire = '0;
`endif

    assign bus.timeout_o = expire;

    always_comb begin : next_state
        for (int unsigned j = 0; j < PORTS; j++) begin
            state_d[j] = state_q[j];
            owner_d[j] = owner_q[j];
            rr_d[j]    = rr_q[j];
`ifdef CROSSBAR_ALLOC_TIMEOUT_EN
            cnt_d[j]   = '0;
`endif
            unique case (state_q[j])
                ALLOC_IDLE: begin
                    if (|gnt[j]) begin
                        state_d[j] = ALLOC_LOCKED;
                        owner_d[j] = gidx[j];
                        rr_d[j]    = DEST_W'((32'(gidx[j]) + 32'd1) % PORTS);
                    end
                end
                ALLOC_LOCKED: begin
                    // Tail transfer or forced release; req_dest is ignored while locked.
                    if (expire[j] || (xfer[j] && bus.req_last[owner_q[j]])) begin
                        state_d[j] = ALLOC_IDLE;
                    end
`ifdef CROSSBAR_ALLOC_TIMEOUT_EN
                    if (!expire[j] && !xfer[j]) cnt_d[j] = cnt_q[j] + CNT_W'(1);
`endif
                end
                default: state_d[j] = ALLOC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) begin
            for (int unsigned j = 0; j < PORTS; j++) begin
                state_q[j] <= ALLOC_IDLE;
                owner_q[j] <= '0;
                rr_q[j]    <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < PORTS; j++) begin
                state_q[j] <= state_d[j];
                owner_q[j] <= owner_d[j];
                rr_q[j]    <= rr_d[j];
            end
        end
    end

    // Crossbar controls are combinational from the lock registers and live handshakes.
    always_comb begin : xbar_outputs
        bus.in_ready     = '0;
        bus.out_valid    = '0;
        bus.xbar_dest    = '0;
        bus.xbar_dest_en = '0;
        bus.lock_o       = '0;
        for (int unsigned j = 0; j < PORTS; j++) begin
            if (state_q[j] == ALLOC_LOCKED) begin
                bus.xbar_dest_en[owner_q[j]] = 1'b1;
                bus.xbar_dest[owner_q[j]]    = DEST_W'(j);
                bus.in_ready[owner_q[j]]     = bus.out_ready[j];
                bus.out_valid[j]             = bus.req_valid[owner_q[j]];
                bus.lock_o[j]                = 1'b1;
            end
        end
    end

endmodule

// File: doc/crossbar_allocator.md
CROSSBAR_ALLOCATOR -- requirements
Module: crossbar_allocator

Interface
REQ-001 SHALL have parameter PORTS, default 4: number of crossbar input and output ports, at least 2.
REQ-002 SHALL have parameter TIMEOUT, default 16: number of stalled locked cycles before forced release (used only under REQ-027).
REQ-003 SHALL have localparam DEST_W = $clog2(PORTS): width of one destination index.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  [PORTS]  input i has a flit.
REQ-008 req_dest  input  DEST_W x [PORTS]  destination output of input i's flit.
REQ-009 req_last  input  [PORTS]  input i's flit is the packet tail.
REQ-010 out_ready  input  [PORTS]  downstream of output j accepts a flit.
REQ-011 in_ready  output  [PORTS]  input i's flit transfers this cycle if req_valid[i] is high.
REQ-012 out_valid  output  [PORTS]  output j carries a valid flit.
REQ-013 xbar_dest  output  DEST_W x [PORTS]  crossbar select for input i.
REQ-014 xbar_dest_en  output  [PORTS]  crossbar enable for input i.
REQ-015 lock_o  output  [PORTS]  output j is locked.
REQ-016 timeout_o  output  [PORTS]  one-cycle pulse when output j is force-released.

Function
REQ-017 Each output j SHALL run a two-state FSM, ALLOC_IDLE or ALLOC_LOCKED, with registers owner[j] and rr_ptr[j].
REQ-018 ALLOC_IDLE SHALL treat input i as eligible when req_valid[i], req_dest[i]==j, and i owns no output; it SHALL pick the first eligible i scanning cyclically from rr_ptr[j].
REQ-019 On a pick, the next cycle SHALL have state ALLOC_LOCKED, owner[j]=i and rr_ptr[j]=(i+1) mod PORTS; with no eligible input, state and rr_ptr[j] SHALL hold.
REQ-020 Allocation latency SHALL be 1 cycle: a request first seen in cycle N can transfer in cycle N+1.
REQ-021 While output j is locked by owner i: xbar_dest_en[i]=1, xbar_dest[i]=j, in_ready[i]=out_ready[j], out_valid[j]=req_valid[i], lock_o[j]=1; all of these SHALL be driven combinationally from registers and current inputs.
REQ-022 A transfer SHALL be req_valid[i] and out_ready[j] in the same cycle; a transfer with req_last[i]=1 SHALL return j to ALLOC_IDLE the next cycle, which gives one mandatory bubble between packets.
REQ-023 Changes to req_dest[owner] while locked SHALL be ignored; the lock stays on j until the tail flit.
REQ-024 Invariants: no input SHALL own more than one output, and no output SHALL have more than one owner; non-owner inputs SHALL see in_ready=0 and xbar_dest_en=0.
REQ-025 Outputs that are not involved in an allocation SHALL drive 0, including xbar_dest.

Reset
REQ-026 rst_n low SHALL immediately force all FSMs to ALLOC_IDLE, owner=0, rr_ptr=0, timeout counters=0 and all outputs to 0; a packet in flight is dropped, not resumed.

Configuration
REQ-027 With CROSSBAR_ALLOC_TIMEOUT_EN defined:
 - each output SHALL count consecutive ALLOC_LOCKED cycles without a transfer;
 - the count SHALL clear on any transfer;
 - when the count reaches TIMEOUT, the output SHALL go to ALLOC_IDLE the next cycle and pulse timeout_o[j] for 1 cycle.
REQ-028 Without CROSSBAR_ALLOC_TIMEOUT_EN, no counter SHALL exist, timeout_o SHALL be tied to 0, and locks SHALL release only on a tail transfer.

Structure
REQ-029 Package crossbar_pkg SHALL hold typedef alloc_state_t (ALLOC_IDLE, ALLOC_LOCKED) and the crossbar PORTS default.
REQ-030 Round-robin selection SHALL live in sub-module rr_arbiter (request vector, pointer -> one-hot grant plus index), instantiated once per output.

Verification (PORTS=4)
REQ-031 Reset: assert rst_n=0 mid-packet -> all outputs read 0 in the same cycle; after release, lock_o=0000.
REQ-032 Single packet: input 1 sends to dest 2, 3 flits, out_ready=1111 from cycle 0 -> lock_o[2]=1 in cycles 1-3, in_ready[1]=1 in cycles 1-3, xbar_dest[1]=2, lock_o[2]=0 in cycle 4.
REQ-033 Round robin: inputs 0, 1 and 3 each stream single-flit packets to dest 0 -> owner sequence 0,1,3,0,1,3, each owner locked for 1 cycle with 1 idle cycle between owners.
REQ-034 Backpressure: out_ready[2]=0 for 5 cycles during the 2nd flit -> lock holds, in_ready[1]=0, no flit is lost, and the packet completes after out_ready returns to 1.
REQ-035 Parallel: input 0 sends to dest 1 and input 1 sends to dest 0 in the same cycle -> both outputs lock in cycle 1 and both packets transfer concurrently.
REQ-036 Timeout (macro defined, TIMEOUT=16): owner drops req_valid after flit 1 -> 16 stalled cycles, then timeout_o[j] pulses and the lock releases the next cycle. Without the macro, the lock holds indefinitely.
